// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button event decoder.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } state_e;

  localparam int DEF_LONG_CYCLES   = 1024;
  localparam int DEF_REPEAT_CYCLES = 256;
  localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/button_edge_det.sv
// One-flop history of the debounced level with rise/fall strobes derived from it.
module button_edge_det (
  input  logic clk,
  input  logic n_reset,
  input  logic db_i,
  output logic rise_o,
  output logic fall_o
);

  logic db_q;

  always_ff @(posedge clk) begin
    if (!n_reset) db_q <= 1'b0;
    else          db_q <= db_i;
  end

  assign rise_o = db_i & ~db_q;
  assign fall_o = ~db_i & db_q;

endmodule

// File: rtl/button_event.sv
// Button event decoder: press / release / long-press and optional auto-repeat pulses.
// Auto-repeat is built only when BUTTON_AUTOREPEAT_EN is defined.
//
// state    | meaning
// ST_IDLE  | button up, counter parked at 0
// ST_PRESS | button down, counting toward long-press
// ST_HELD  | long-press reached, waiting for release (repeat timer if enabled)
module button_event
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic n_reset,
  input  logic db_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);

  logic rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  button_edge_det u_edge (
    .clk     (clk),
    .n_reset (n_reset),
    .db_i    (db_in),
    .rise_o  (rise),
    .fall_o  (fall)
  );

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYCLES - 1);
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  // Fall is tested first so a release always beats a coinciding terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rise) state_d = ST_PRESS;
      ST_PRESS: begin
        if (fall)                  state_d = ST_IDLE;
        else if (cnt_q == LONG_TC) state_d = ST_HELD;
      end
      ST_HELD:  if (fall) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        press_d = rise;
      end
      ST_PRESS: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == LONG_TC) begin
          long_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
          if (cnt_q == REP_TC) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      default: cnt_d = '0;
    endcase
    held_d = (state_d != ST_IDLE);
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed scenarios then random press/hold/release
// traffic, checked every cycle against a hold-duration reference model.
module tb_button_event;

  localparam int LONG = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic db_in = 1'b0;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

  int n_checks = 0;
  int n_pass   = 0;

  // model: previous sampled level and number of edges since the press edge
  logic m_prev = 1'b0;
  int   m_hold = 0;
  logic e_press, e_release, e_long, e_repeat, e_held;
  int   cyc = 0;

  button_event #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .db_in         (db_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
  endtask

  task automatic step(input logic d, input logic r);
    db_in   = d;
    n_reset = r;
    @(posedge clk);
    cyc++;
    e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
    if (!r) begin
      m_prev = 0; m_hold = 0; e_held = 0;
    end else begin
      if (d && !m_prev) begin
        e_press = 1;
        m_hold  = 0;
      end else if (!d && m_prev) begin
        e_release = 1;
      end else if (d) begin
        m_hold++;
        if (m_hold == LONG) e_long = 1;
`ifdef BUTTON_AUTOREPEAT_EN
        else if (m_hold > LONG && ((m_hold - LONG) % REP) == 0) e_repeat = 1;
`endif
      end
      e_held = d;
      m_prev = d;
    end
    #1;
    check("press_pulse",   press_pulse,   e_press);
    check("release_pulse", release_pulse, e_release);
    check("long_pulse",    long_pulse,    e_long);
    check("repeat_pulse",  repeat_pulse,  e_repeat);
    check("held",          held,          e_held);
    check("pulse_onehot0",
          ($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) <= 1), 1'b1);
  endtask

  task automatic run(input logic d, input logic r, input int n);
    for (int i = 0; i < n; i++) step(d, r);
  endtask

  initial begin
    // reset then idle
    run(0, 0, 3);
    run(0, 1, 20);
    // short press
    run(1, 1, 5);
    run(0, 1, 6);
    // long hold with repeats (if enabled)
    run(1, 1, 30);
    run(0, 1, 6);
    // fall sampled on the edge where the long terminal count would hit
    run(1, 1, LONG);
    run(0, 1, 6);
    // reset mid-hold with the button still down
    run(1, 1, LONG + 4);
    run(1, 0, 1);
    run(1, 1, LONG + 6);
    run(0, 1, 4);
    // random traffic
    for (int b = 0; b < 120; b++) begin
      run(0, 1, $urandom_range(1, 6));
      if ($urandom_range(0, 15) == 0) begin
        run(1, 1, $urandom_range(1, 20));
        run($urandom_range(0, 1), 0, $urandom_range(1, 2));
      end
      run(1, 1, $urandom_range(1, 3 * LONG + 2 * REP));
    end
    run(0, 1, 4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_event.md
# button_event

Event decoder that sits after the debouncer on each push-button input. It turns a clean, debounced button level into single-cycle events for the processor control logic: press, release, long-press and (optionally) auto-repeat. It is the consumer end of the button conditioning path: the debouncer cleans the level, and this block interprets it.

## Interface
- `LONG_CYCLES`, default 1024: cycles the button must be held after the press before `long_pulse` fires; legal range 2..2^CNT_W.
- `REPEAT_CYCLES`, default 256: period of `repeat_pulse` while held past long-press; legal range 2..2^CNT_W.
- `CNT_W`, default 16: width of the internal hold/repeat counter.
- `clk`  in  1  clock; all logic on rising edge.
- `n_reset`  in  1  reset, synchronous, active-low.
- `db_in`  in  1  debounced button level, active-high, synchronous to `clk`.
- `press_pulse`  out  1  one-cycle pulse on button press.
- `release_pulse`  out  1  one-cycle pulse on button release.
- `long_pulse`  out  1  one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse`  out  1  one-cycle periodic pulse while held past long-press (only when the macro is defined).
- `held`  out  1  level; high while the FSM is in PRESS or HELD.

## Operation
- `db_q` is a one-flop copy of `db_in`.
  - rise = `db_in & ~db_q`
  - fall = `~db_in & db_q`
- All outputs are registered. Reset value of every output, of `db_q`, and of `cnt` is 0; the state resets to IDLE.
- FSM states and transitions:
  - IDLE: `cnt` is held at 0. On rise: `press_pulse` <= 1, `cnt` <= 0, go to PRESS.
  - PRESS: `cnt` increments each cycle.
    - On fall: `release_pulse` <= 1, go to IDLE.
    - Otherwise, when `cnt == LONG_CYCLES-1`: `long_pulse` <= 1, `cnt` <= 0, go to HELD.
  - HELD:
    - On fall: `release_pulse` <= 1, go to IDLE.
    - Otherwise, with the macro defined: `cnt` increments; when `cnt == REPEAT_CYCLES-1`, `repeat_pulse` <= 1 and `cnt` <= 0.
    - Otherwise, without the macro: `cnt` is frozen.
- Simultaneous events: fall takes priority. If fall coincides with the long or repeat terminal count, only `release_pulse` fires.
- Arithmetic: `cnt` is CNT_W unsigned. It never wraps, because the terminal compare clears it first.
- At most one of the four pulse outputs is high in any cycle.
- Reset mid-operation: everything returns to reset values, with no release event. If `db_in` is still high after reset, the next edge sees a rise, so `press_pulse` fires one cycle after `n_reset` deasserts.
- A rise while in PRESS or HELD cannot occur, because `db_q` is already 1.

## Timing
- Let `db_in` be first sampled high at edge E0.
- `press_pulse` is high for the cycle following E0 (1-cycle latency). `held` rises in the same cycle.
- `long_pulse` is high exactly `LONG_CYCLES` cycles after `press_pulse`.
- First `repeat_pulse` is high `REPEAT_CYCLES` cycles after `long_pulse`, then every `REPEAT_CYCLES` cycles after that.
- Let `db_in` be first sampled low at edge F0. `release_pulse` is high for the cycle following F0, and `held` falls in that same cycle.
- Pulses are exactly one cycle wide, with no back-to-back repeats.

## Configuration
- Macro `BUTTON_AUTOREPEAT_EN`.
- Defined: the HELD state generates periodic `repeat_pulse`.
- Undefined: the repeat compare logic is compiled out, `repeat_pulse` is tied to 0, and the `REPEAT_CYCLES` parameter is ignored. HELD only waits for release.

## Structure
- Shared package `button_pkg` holds:
  - the state typedef (IDLE, PRESS, HELD);
  - default constants for `LONG_CYCLES`, `REPEAT_CYCLES` and `CNT_W`.
- One sub-module, `button_edge_det`: the `db_q` flop plus rise/fall outputs, with synchronous active-low reset to 0.
- The FSM, counter and output registers live in `button_event`.

## Test plan
All scenarios use `LONG_CYCLES`=8 and `REPEAT_CYCLES`=4.
- Reset then idle: with `n_reset`=0 for 3 cycles and `db_in`=0, all outputs stay 0 and the state stays IDLE throughout, including 20 cycles after reset release.
- Short press: `db_in` high for 5 cycles. Expect `press_pulse` at cycle +1, `release_pulse` 1 cycle after the fall, no `long_pulse`, and `held` high for 5 cycles.
- Long hold, macro defined: `db_in` high for 30 cycles.
  - `press_pulse` at t+1.
  - `long_pulse` at t+9.
  - `repeat_pulse` at t+13, t+17, t+21, t+25, t+29.
  - `release_pulse` after the fall.
- Long hold, macro undefined: same stimulus. Expect `long_pulse` at t+9, `repeat_pulse` never asserted, and `release_pulse` after the fall.
- Release at terminal count: drop `db_in` so the fall is sampled on the edge where `cnt`=7 in PRESS. Expect only `release_pulse`, with no `long_pulse`.
- Reset mid-hold: with `db_in`=1 in HELD, pulse `n_reset` low for 1 cycle while `db_in` stays high. Expect outputs cleared, no `release_pulse`, then `press_pulse` one cycle after reset deasserts.
